// File: rtl/vx_tcu_fedp_seq.sv
// rtl/vx_tcu_fedp_seq.sv - sequences K-step dot-product accumulation through one FEDP pipeline
module vx_tcu_fedp_seq #(
    parameter int N       = 2,
    parameter int LATENCY = 13,
    parameter int KW      = 8,
    parameter int TAGW    = 4,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt_s,
    input  logic [KW-1:0]     req_k,
    input  logic [XLEN-1:0]   req_c,
    input  logic [TAGW-1:0]   req_tag,
    input  logic              opd_valid,
    output logic              opd_ready,
    input  logic [N*XLEN-1:0] opd_a_row,
    input  logic [N*XLEN-1:0] opd_b_col,
    output logic              fedp_enable,
    output logic [2:0]        fedp_fmt_s,
    output logic [N*XLEN-1:0] fedp_a_row,
    output logic [N*XLEN-1:0] fedp_b_col,
    output logic [XLEN-1:0]   fedp_c_val,
    input  logic [XLEN-1:0]   fedp_d_val,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_d,
    output logic [TAGW-1:0]   rsp_tag,
    output logic              busy
);

    // A zero-latency pipeline would leave no cycle in which to wait for the result
    if (LATENCY < 1) begin : g_bad_latency
        $error("vx_tcu_fedp_seq: LATENCY must be >= 1");
    end

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [KW-1:0]   rem, rem_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic [TAGW-1:0] tag, tag_nxt;
    logic [2:0]      fmt, fmt_nxt;

    // Operand chunks go straight to the pipeline; C is always the running accumulator
    assign fedp_a_row = opd_a_row;
    assign fedp_b_col = opd_b_col;
    assign fedp_c_val = acc;
    assign fedp_fmt_s = fmt;
    assign rsp_d      = acc;
    assign rsp_tag    = tag;

    // Next-state and handshake decode; the result is sampled only when the countdown expires,
    // so anything else sitting in the pipeline is never captured
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        rem_nxt     = rem;
        wait_nxt    = wait_cnt;
        tag_nxt     = tag;
        fmt_nxt     = fmt;
        req_ready   = reset && (state == S_IDLE);
        opd_ready   = (state == S_ISSUE);
        fedp_enable = (state == S_ISSUE) || (state == S_WAIT);
        rsp_valid   = (state == S_DONE);
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    fmt_nxt   = req_fmt_s;
                    tag_nxt   = req_tag;
                    acc_nxt   = req_c;
                    rem_nxt   = req_k;
                    state_nxt = (req_k == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // rem is at least 1 here, so the decrement cannot underflow
                if (opd_valid) begin
                    rem_nxt   = rem - KW'(1);
                    wait_nxt  = WAIT_INIT;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    acc_nxt   = fedp_d_val;
                    state_nxt = (rem == '0) ? S_DONE : S_ISSUE;
                end else begin
                    wait_nxt = wait_cnt - CW'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            rem      <= '0;
            wait_cnt <= '0;
            tag      <= '0;
            fmt      <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            rem      <= rem_nxt;
            wait_cnt <= wait_nxt;
            tag      <= tag_nxt;
            fmt      <= fmt_nxt;
        end
    end

endmodule
